sseg_scan4: RTL
===============

# sseg_scan4

Time-multiplexed driver for the board's 4-digit common-anode seven-segment display. It takes a 16-bit hex/BCD value from an upstream counter, latches it once per scan frame to avoid tearing, and drives the active-low `sseg` and `en_dig` pins directly. It inserts an anti-ghosting blank interval at the start of every digit slot and supports optional leading-zero suppression.

## Interface
- `SCAN_DIV`, default 50000: clock cycles per digit slot. Must be ≥ `BLANK_CYC`+2.
- `BLANK_CYC`, default 16: cycles at the start of each slot with all digits off. 0 disables blanking.
- `clk`  input  1  system clock; all state changes on the rising edge.
- `reset`  input  1  asynchronous, active-low reset.
- `value`  input  16  four nibbles; `[3:0]` is digit 0 (rightmost), `[15:12]` is digit 3.
- `dp`  input  4  decimal point per digit, active-high; `dp[i]` belongs to digit i.
- `lz`  input  1  1 = enable leading-zero suppression.
- `sseg`  output  8  segment cathodes, active-low: `[0]`=a, `[1]`=b … `[6]`=g, `[7]`=dp.
- `en_dig`  output  4  digit anodes, active-low, at most one bit low; `en_dig[i]` is digit i.
- `frame_tick`  output  1  one-cycle high pulse in the cycle the shadow registers load.

## Operation
- Prescaler `pre` counts 0…`SCAN_DIV`-1 and wraps. Digit index `idx` (2 bit) advances 0→1→2→3→0 on each `pre` wrap.
- Shadow registers hold `value`, `dp` and `lz`. They load in the cycle where `pre`=`SCAN_DIV`-1 and `idx`=3, and also in the first clock after reset deasserts (a load-pending flag is set by reset). `frame_tick`=1 in exactly those cycles.
- Display never reads live inputs. Input changes mid-frame appear only after the next load.
- Slot behaviour, for the output cycle mapped to (`pre`, `idx`):
  - `pre` < `BLANK_CYC`: `en_dig`=4'b1111, `sseg`=8'hFF.
  - Otherwise: `en_dig` has only bit `idx` low. `sseg[6:0]` is the glyph of shadow nibble `idx`. `sseg[7]` = ~shadow `dp[idx]`.
- Glyphs, listing the lit segments (a lit segment drives 0):
  - 0 abcdef, 1 bc, 2 abdeg, 3 abcdg
  - 4 bcfg, 5 acdfg, 6 acdefg, 7 abc
  - 8 abcdefg, 9 abcdfg, A abcefg, b cdefg
  - C adef, d bcdeg, E adefg, F aefg
- Leading-zero suppression (shadow `lz`=1):
  - Digit i∈{3,2,1} is suppressed when nibble i and all higher nibbles are 0.
  - A suppressed digit drives `sseg[6:0]`=7'h7F.
  - Its dp is still driven from `dp[i]`, and its anode is still enabled.
  - Digit 0 is never suppressed.
- Reset (`reset`=0), asynchronous and effective immediately, even mid-slot:
  - `pre`=0, `idx`=0, shadow=0.
  - `en_dig`=4'b1111, `sseg`=8'hFF, `frame_tick`=0.

## Timing
- `sseg`, `en_dig` and `frame_tick` are registered. Each reflects the counter state of the preceding cycle, a one-cycle pipeline.
- Clock count after reset deasserts: edge 1 loads the shadow, and `frame_tick` is high until edge 2. Outputs follow slot 0 from edge 2 onward.
- Slot length is exactly `SCAN_DIV` cycles. Frame length is 4·`SCAN_DIV` cycles, and `frame_tick` period equals the frame length.
- Within each slot, the blank interval is `BLANK_CYC` cycles, followed by `SCAN_DIV`-`BLANK_CYC` cycles with the digit on.
- No output glitches. `en_dig` never has two bits low in any cycle, including across slot boundaries.
- Load and display of the new frame: the shadow loaded at the end of slot 3 is used from the next slot-0 output cycle.

## Test plan
- Reset values, with `SCAN_DIV`=8 and `BLANK_CYC`=2:
  - Hold `reset`=0 → `en_dig`=1111, `sseg`=FF, `frame_tick`=0.
  - Release → `frame_tick` pulses once after one edge.
  - Then `en_dig` sequence is 1111,1111,1110×6,1111,1111,1101×6 …, and the `frame_tick` period is 32 cycles.
- Glyphs: `value`=16'h12AF, `dp`=4'b0100, `lz`=0.
  - Digit 0 `sseg`=8'h8E (F).
  - Digit 1 `sseg`=8'h88 (A).
  - Digit 2 `sseg`=8'h24 (2 with dp).
  - Digit 3 `sseg`=8'hF9 (1).
- Tearing: change `value` from 16'h1111 to 16'h2222 during slot 1.
  - Slots 2 and 3 still show 1 (8'hF9).
  - The next frame shows 2 (8'hA4) on all digits.
- Leading zeros: `value`=16'h0045, `lz`=1 → digits 3 and 2 `sseg`=8'hFF with anode enabled, digit 1 8'h99, digit 0 8'h92. With `value`=16'h0000, only digit 0 shows 0 (8'hC0).
- Reset mid-operation: assert `reset` at `pre`=5, `idx`=2 → outputs go to 1111/FF in the same cycle with no clock edge. After release, the scan restarts at slot 0 with a fresh shadow load.
- Exhaustive one-hot check: run 3 frames with random `value` and `dp` each frame. Assert every cycle that `en_dig` has at most one bit low, and that the glyph matches the latched value.

Source files
------------

// File: rtl/sseg_scan4_if.sv
// Bus between the upstream counter logic and the 4-digit seven-segment scanner.
// The master supplies the value to display and observes the pin-level outputs.
interface sseg_scan4_if;
   logic [15:0] value;
   logic [3:0]  dp;
   logic        lz;
   logic [7:0]  sseg;
   logic [3:0]  en_dig;
   logic        frame_tick;

   modport master (
      output value, dp, lz,
      input  sseg, en_dig, frame_tick
   );

   modport slave (
      input  value, dp, lz,
      output sseg, en_dig, frame_tick
   );
endinterface

// File: rtl/sseg_scan4.sv
// Time-multiplexed common-anode 4-digit seven-segment driver with per-frame
// shadow latching, anti-ghosting blank interval and leading-zero suppression.
module sseg_scan4 #(
   parameter int SCAN_DIV  = 50000,
   parameter int BLANK_CYC = 16
) (
   input  logic clk,
   input  logic reset,
   sseg_scan4_if.slave bus
);
   localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [PW-1:0] PRE_LAST  = PW'(SCAN_DIV - 1);
   localparam logic [PW-1:0] BLANK_END = PW'(BLANK_CYC);

   logic [PW-1:0] pre;
   logic [1:0]    idx;
   logic          load_pend;
   logic [15:0]   sh_value;
   logic [3:0]    sh_dp;
   logic          sh_lz;
   logic          pre_wrap;
   logic          load;

   logic [3:0]    nibble;
   logic          suppress;
   logic [7:0]    next_sseg;
   logic [3:0]    next_en;
   logic [7:0]    sseg_q;
   logic [3:0]    en_q;
   logic          tick_q;

   assign pre_wrap = (pre == PRE_LAST);
   assign load     = load_pend | (pre_wrap & (idx == 2'd3));

   // Active-low glyph for segments g..a (bit 0 = a).
   function automatic logic [6:0] glyph(input logic [3:0] n);
      case (n)
         4'h0: glyph = 7'h40;
         4'h1: glyph = 7'h79;
         4'h2: glyph = 7'h24;
         4'h3: glyph = 7'h30;
         4'h4: glyph = 7'h19;
         4'h5: glyph = 7'h12;
         4'h6: glyph = 7'h02;
         4'h7: glyph = 7'h78;
         4'h8: glyph = 7'h00;
         4'h9: glyph = 7'h10;
         4'hA: glyph = 7'h08;
         4'hB: glyph = 7'h03;
         4'hC: glyph = 7'h46;
         4'hD: glyph = 7'h21;
         4'hE: glyph = 7'h06;
         default: glyph = 7'h0E;
      endcase
   endfunction

   // The load-pending cycle after reset holds the counters so that the first
   // frame is as long as every later one.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pre       <= '0;
         idx       <= 2'd0;
         load_pend <= 1'b1;
      end else if (load_pend) begin
         load_pend <= 1'b0;
      end else if (pre_wrap) begin
         pre <= '0;
         idx <= idx + 2'd1;
      end else begin
         pre <= pre + PW'(1);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sh_value <= 16'h0000;
         sh_dp    <= 4'h0;
         sh_lz    <= 1'b0;
      end else if (load) begin
         sh_value <= bus.value;
         sh_dp    <= bus.dp;
         sh_lz    <= bus.lz;
      end
   end

   always_comb begin
      nibble    = sh_value[{idx, 2'b00} +: 4];
      suppress  = 1'b0;
      next_sseg = 8'hFF;
      next_en   = 4'hF;
      case (idx)
         2'd3:    suppress = sh_lz & (sh_value[15:12] == 4'h0);
         2'd2:    suppress = sh_lz & (sh_value[15:8] == 8'h00);
         2'd1:    suppress = sh_lz & (sh_value[15:4] == 12'h000);
         default: suppress = 1'b0;
      endcase
      if (!load_pend && !(pre < BLANK_END)) begin
         next_en   = ~(4'b0001 << idx);
         next_sseg = {~sh_dp[idx], suppress ? 7'h7F : glyph(nibble)};
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sseg_q <= 8'hFF;
         en_q   <= 4'hF;
         tick_q <= 1'b0;
      end else begin
         sseg_q <= next_sseg;
         en_q   <= next_en;
         tick_q <= load;
      end
   end

   assign bus.sseg       = sseg_q;
   assign bus.en_dig     = en_q;
   assign bus.frame_tick = tick_q;
endmodule
